mem_stage: RTL

//  Memory-access stage between execute and write-back of the cpu0 core. Accepts the ALU result

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: cpu0 load/store stage over a req/gnt/rvalid bus; define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// Latency: ALU op 1, store 1+gnt wait, load >=3; ex_ready_o is low whenever a dmem transaction is in flight.
module mem_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int RSLEN    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [XLEN-1:0]  ex_alu_out_i,
  input  logic [XLEN-1:0]  ex_store_data_i,
  input  logic             ex_mem_rd_i,
  input  logic             ex_mem_wr_i,
  input  logic [1:0]       ex_mem_size_i,
  input  logic             ex_mem_unsigned_i,
  input  logic [RSLEN-1:0] ex_rsd_i,
  input  logic             ex_wb_we_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [XLEN-1:0]  dmem_addr_o,
  output logic [3:0]       dmem_be_o,
  output logic [XLEN-1:0]  dmem_wdata_o,
  input  logic             dmem_gnt_i,
  input  logic             dmem_rvalid_i,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [RSLEN-1:0] wb_rsd_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             misalign_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_addr, r_wdata, r_wb_data;
  logic [3:0]       r_be;
  logic [1:0]       r_size;
  logic             r_we, r_uns, r_ld_we;
  logic [RSLEN-1:0] r_rsd, r_wb_rsd;
  logic             r_wb_vld, r_wb_we, r_misal;

  logic             w_accept, w_mem_op, w_trap, w_take_mem;
  logic [XLEN-1:0]  w_addr_al, w_wdata, w_shift, w_ld_data, w_wb_data;
  logic [3:0]       w_be;
  logic [RSLEN-1:0] w_wb_rsd;
  logic             w_wb_vld, w_wb_we, w_misal_pulse;

  assign ex_ready_o = (r_state == S_IDLE);
  assign w_accept   = ex_valid_i && ex_ready_o;
  assign w_mem_op   = ex_mem_rd_i || ex_mem_wr_i;
  assign w_take_mem = w_accept && w_mem_op && !w_trap;

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal = (ex_mem_size_i == 2'b01) ? ex_alu_out_i[0]
                                            : (ex_mem_size_i[1] && (ex_alu_out_i[1:0] != 2'b00));
  assign w_trap  = w_accept && w_mem_op && w_misal;
`else
  assign w_trap  = 1'b0;
`endif

  // Low address bits are forced to the access size, so a non-trapping misaligned access proceeds aligned.
  always_comb begin
    w_addr_al = ex_alu_out_i;
    w_be      = 4'b1111;
    w_wdata   = ex_store_data_i;
    case (ex_mem_size_i)
      2'b00: begin
        w_be    = 4'b0001 << ex_alu_out_i[1:0];
        w_wdata = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        w_addr_al[0] = 1'b0;
        w_be         = 4'b0011 << {ex_alu_out_i[1], 1'b0};
        w_wdata      = {2{ex_store_data_i[15:0]}};
      end
      default: w_addr_al[1:0] = 2'b00;
    endcase
  end

  assign w_shift = dmem_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_size)
      2'b00:   w_ld_data = {{24{w_shift[7] & ~r_uns}}, w_shift[7:0]};
      2'b01:   w_ld_data = {{16{w_shift[15] & ~r_uns}}, w_shift[15:0]};
      default: w_ld_data = w_shift;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wb_vld      = 1'b0;
    w_wb_we       = 1'b0;
    w_wb_rsd      = r_wb_rsd;
    w_wb_data     = r_wb_data;
    w_misal_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_trap) begin
            w_wb_vld      = 1'b1;
            w_wb_rsd      = ex_rsd_i;
            w_misal_pulse = 1'b1;
          end else if (w_mem_op) begin
            w_state_nxt = S_REQ;
          end else begin
            w_wb_vld  = 1'b1;
            w_wb_we   = ex_wb_we_i;
            w_wb_rsd  = ex_rsd_i;
            w_wb_data = ex_alu_out_i;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          if (r_we) begin
            w_state_nxt = S_IDLE;
            w_wb_vld    = 1'b1;
            w_wb_rsd    = r_rsd;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          w_state_nxt = S_IDLE;
          w_wb_vld    = 1'b1;
          w_wb_we     = r_ld_we;
          w_wb_rsd    = r_rsd;
          w_wb_data   = w_ld_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_size    <= '0;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_ld_we   <= 1'b0;
      r_rsd     <= '0;
      r_wb_vld  <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_rsd  <= '0;
      r_wb_data <= '0;
      r_misal   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wb_vld  <= w_wb_vld;
      r_wb_we   <= w_wb_we;
      r_wb_rsd  <= w_wb_rsd;
      r_wb_data <= w_wb_data;
      r_misal   <= w_misal_pulse;
      if (w_take_mem) begin
        r_addr  <= w_addr_al;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_size  <= ex_mem_size_i;
        r_we    <= ex_mem_wr_i;
        r_uns   <= ex_mem_unsigned_i;
        r_ld_we <= ex_wb_we_i;
        r_rsd   <= ex_rsd_i;
      end
    end
  end

  // Bus fields read as zero outside the request phase.
  assign dmem_req_o   = (r_state == S_REQ);
  assign dmem_we_o    = dmem_req_o & r_we;
  assign dmem_addr_o  = dmem_req_o ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? r_be : 4'b0000;
  assign dmem_wdata_o = dmem_req_o ? r_wdata : '0;

  assign wb_valid_o = r_wb_vld;
  assign wb_we_o    = r_wb_we;
  assign wb_rsd_o   = r_wb_rsd;
  assign wb_data_o  = r_wb_data;
  assign misalign_o = r_misal;
endmodule
